// File: rtl/im_arbiter.sv
// ============================================================================
// im_arbiter: shares the IM read port between IF fetch and debug reads.
// Optional IM_ARB_RANGE_CHECK_EN rejects misaligned/out-of-range debug reads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module im_arbiter #(
    parameter int          ADDRBITS     = 12,
    parameter logic [31:0] BASE         = 32'h3000,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic        if_req,
    output logic [31:0] if_instr,
    output logic        if_stall,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic [31:0] im_a,
    input  logic [31:0] im_rd
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam int              CNT_W     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      lat_addr;
    logic             addr_bad;
    logic             wait_done;

`ifdef IM_ARB_RANGE_CHECK_EN
    localparam logic [32:0] ADDR_END = {1'b0, BASE} + (33'd4 << ADDRBITS);
    assign addr_bad = (dbg_addr[1:0] != 2'b00) || (dbg_addr < BASE) ||
                      ({1'b0, dbg_addr} >= ADDR_END);
`else
    assign addr_bad = 1'b0;
`endif

    // Fetch yields the port once it goes quiet or the debug read has waited long enough.
    assign wait_done = !if_req || (starve_cnt == LIMIT_CNT);
    assign if_instr  = im_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (dbg_req) next_state = addr_bad ? ACK : WAIT;
            WAIT: begin
                if (!dbg_req) begin
                    next_state = IDLE;
                end else if (wait_done) begin
                    next_state = GRANT;
                end
            end
            GRANT:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Reset masks the outputs immediately so an abandoned transaction never leaks out.
    always_comb begin
        dbg_ack  = (state == ACK) && !reset;
        if_stall = (state == GRANT) && if_req && !reset;
        im_a     = ((state == GRANT) && !reset) ? lat_addr : if_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            lat_addr   <= '0;
            dbg_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbg_req) begin
                        lat_addr   <= dbg_addr;
                        starve_cnt <= '0;
                        if (addr_bad) dbg_rdata <= '0;
                    end
                end
                WAIT:    if (dbg_req && !wait_done) starve_cnt <= starve_cnt + 1'b1;
                GRANT:   dbg_rdata <= im_rd;
                default: ;
            endcase
        end
    end

`ifdef IM_ARB_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_err <= 1'b0;
        end else if (state == GRANT) begin
            dbg_err <= 1'b0;
        end else if ((state == IDLE) && dbg_req && addr_bad) begin
            dbg_err <= 1'b1;
        end
    end
`else
    assign dbg_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_im_arbiter.sv
// ============================================================================
// tb_im_arbiter: randomized transaction-level checks of im_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_im_arbiter;

    localparam int          ADDRBITS = 12;
    localparam logic [31:0] BASE     = 32'h3000;
    localparam int          STARVE   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_req;
    logic [31:0] if_instr;
    logic        if_stall;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_err;
    logic [31:0] im_a;
    logic [31:0] im_rd;

    logic [31:0] mem [0:(1<<ADDRBITS)-1];
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int unsigned widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) & ((32'd1 << ADDRBITS) - 1));
    endfunction

    assign im_rd = mem[widx(im_a)];

    always #5 clk = ~clk;

    im_arbiter #(.ADDRBITS(ADDRBITS), .BASE(BASE), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_req(if_req),
        .if_instr(if_instr), .if_stall(if_stall), .dbg_req(dbg_req),
        .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .dbg_err(dbg_err), .im_a(im_a), .im_rd(im_rd)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One debug read accepted in relative cycle 0; pat[c] is if_req in relative cycle c.
    task automatic run_txn(input logic [31:0] addr, input logic [15:0] pat, input string tag);
        int w;
        int g;
        logic [31:0] exp_data;
        logic [31:0] exp_a;
        w = 0;
        while (pat[1+w] && w < STARVE) w++;
        g = 2 + w;
        exp_data = mem[widx(addr)];
        for (int c = 0; c <= g + 1; c++) begin
            next_cycle();
            dbg_req  = 1'b1;
            dbg_addr = (c == 0) ? addr : $urandom;
            if_req   = pat[c];
            if_pc    = $urandom;
            #3;
            exp_a = (c == g) ? addr : if_pc;
            n_cmp++;
            if (dbg_ack !== (c == g + 1)) begin
                n_fail++;
                $display("FAIL %s ack c%0d: got %b want %b", tag, c, dbg_ack, (c == g + 1));
            end
            n_cmp++;
            if (if_stall !== (c == g && pat[c])) begin
                n_fail++;
                $display("FAIL %s stall c%0d: got %b want %b", tag, c, if_stall, (c == g && pat[c]));
            end
            n_cmp++;
            if (im_a !== exp_a) begin
                n_fail++;
                $display("FAIL %s im_a c%0d: got %h want %h", tag, c, im_a, exp_a);
            end
            n_cmp++;
            if (if_instr !== mem[widx(exp_a)]) begin
                n_fail++;
                $display("FAIL %s if_instr c%0d: got %h want %h", tag, c, if_instr, mem[widx(exp_a)]);
            end
        end
        n_cmp++;
        if (dbg_rdata !== exp_data) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", tag, dbg_rdata, exp_data);
        end
        n_cmp++;
        if (dbg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s err: got %b want 0", tag, dbg_err);
        end
        next_cycle();
        dbg_req = 1'b0;
        if_req  = $urandom;
        if_pc   = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; dbg_req = 1'b0; dbg_addr = '0; if_req = 1'b1; if_pc = 32'h3010;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            if_pc = $urandom;
            #3;
            n_cmp++;
            if (dbg_ack !== 1'b0 || if_stall !== 1'b0 || dbg_rdata !== 32'h0 ||
                dbg_err !== 1'b0 || im_a !== if_pc) begin
                n_fail++;
                $display("FAIL reset c%0d: got ack=%b stall=%b rdata=%h err=%b im_a=%h want 0/0/0/0/%h",
                         c, dbg_ack, if_stall, dbg_rdata, dbg_err, im_a, if_pc);
            end
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset_in_grant();
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            dbg_req  = (c < 3);
            dbg_addr = 32'h3004;
            reset    = (c == 2);
            if_req   = (c >= 2);
            if_pc    = $urandom;
            #3;
            n_cmp++;
            if (dbg_ack !== 1'b0 || if_stall !== 1'b0 || im_a !== if_pc || dbg_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL rst_grant c%0d: got ack=%b stall=%b im_a=%h rdata=%h want 0/0/%h/0",
                         c, dbg_ack, if_stall, im_a, dbg_rdata, if_pc);
            end
        end
        run_txn(32'h3004, 16'h0000, "after_rst");
    endtask

    task automatic test_abort();
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            dbg_req  = (c < 2);
            dbg_addr = 32'h3008;
            if_req   = 1'b1;
            if_pc    = $urandom;
            #3;
            n_cmp++;
            if (dbg_ack !== 1'b0 || if_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL abort c%0d: got ack=%b stall=%b want 0/0", c, dbg_ack, if_stall);
            end
        end
        run_txn(32'h300C, 16'hFFFF, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a0;
        logic [31:0] a1;
        a0 = BASE + 4 * ($urandom % (1 << ADDRBITS));
        a1 = BASE + 4 * ($urandom % (1 << ADDRBITS));
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            dbg_req  = (c < 8);
            dbg_addr = (c < 4) ? a0 : a1;
            if_req   = 1'b0;
            if_pc    = $urandom;
            #3;
            n_cmp++;
            if (dbg_ack !== (c == 3 || c == 7)) begin
                n_fail++;
                $display("FAIL b2b ack c%0d: got %b want %b", c, dbg_ack, (c == 3 || c == 7));
            end
            if (c == 2 || c == 6) begin
                n_cmp++;
                if (im_a !== ((c == 2) ? a0 : a1)) begin
                    n_fail++;
                    $display("FAIL b2b im_a c%0d: got %h want %h", c, im_a, (c == 2) ? a0 : a1);
                end
            end
            if (c == 3 || c == 8) begin
                n_cmp++;
                if (dbg_rdata !== mem[widx((c == 3) ? a0 : a1)]) begin
                    n_fail++;
                    $display("FAIL b2b rdata c%0d: got %h want %h", c, dbg_rdata, mem[widx((c == 3) ? a0 : a1)]);
                end
            end
        end
    endtask

`ifdef IM_ARB_RANGE_CHECK_EN
    task automatic test_range();
        logic [31:0] bad [3];
        bad[0] = 32'h2FFC;
        bad[1] = 32'h3002;
        bad[2] = BASE + 4 * (1 << ADDRBITS);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 2; c++) begin
                next_cycle();
                dbg_req  = 1'b1;
                dbg_addr = (c == 0) ? bad[k] : $urandom;
                if_req   = $urandom;
                if_pc    = $urandom;
                #3;
                n_cmp++;
                if (dbg_ack !== (c == 1) || if_stall !== 1'b0 || im_a !== if_pc) begin
                    n_fail++;
                    $display("FAIL range%0d c%0d: got ack=%b stall=%b im_a=%h want %b/0/%h",
                             k, c, dbg_ack, if_stall, im_a, (c == 1), if_pc);
                end
            end
            n_cmp++;
            if (dbg_err !== 1'b1 || dbg_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL range%0d result: got err=%b rdata=%h want 1/0", k, dbg_err, dbg_rdata);
            end
            next_cycle();
            dbg_req = 1'b0;
            run_txn(BASE + 32'h10, 16'h0000, "range_clear");
        end
    endtask
`else
    task automatic test_alias();
        run_txn(BASE + 4 * (1 << ADDRBITS) + 32'h8, $urandom, "alias_hi");
        run_txn(32'h2FFC, $urandom, "alias_lo");
        run_txn(32'h3002, 16'h0000, "alias_mis");
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        for (int t = 0; t < 40; t++) begin
            for (int gap = $urandom_range(0, 3); gap > 0; gap--) begin
                next_cycle();
                dbg_req = 1'b0;
                if_req  = $urandom;
                if_pc   = $urandom;
            end
            a = BASE + 4 * ($urandom % (1 << ADDRBITS));
            run_txn(a, 16'($urandom | $urandom), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDRBITS); i++) mem[i] = $urandom;
        mem[1] = 32'h2408000A;
        test_reset();
        test_reset_in_grant();
        run_txn(32'h3004, 16'h0000, "uncontested");
        run_txn(32'h3000, 16'hFFFF, "starve");
        test_abort();
        test_back_to_back();
`ifdef IM_ARB_RANGE_CHECK_EN
        test_range();
`else
        test_alias();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
